period_down_counter: RTL and testbench

PERIOD_DOWN_COUNTER -- requirements
Module: period_down_counter

---
 rtl/period_down_counter.sv | 103 ++++++++++
 tb/tb_period_down_counter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_down_counter.sv
// Programmable period down-counter with shadow-register reload, auto-reload/one-shot modes.
// Optional terminal-count event counter (tc_cnt) enabled by defining PDC_TC_COUNT_EN.
module period_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy
`ifdef PDC_TC_COUNT_EN
  ,
  output logic [15:0]      tc_cnt
`endif
);

  localparam int unsigned TC_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             load_fire;

  assign load_ready = ~pending;
  assign load_fire  = load_valid & ~pending;
  assign zero       = (count == '0);
  assign busy       = (state == RUN);

  // Control FSM, count register and shadow handshake. The handshake is applied
  // last so a same-edge load lands after any reload has consumed the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      shadow   <= '0;
      pending  <= 1'b0;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              count   <= shadow;
              pending <= 1'b0;
              state   <= RUN;
            end
          end
          RUN: begin
            if (en) begin
              if (count != '0) begin
                count <= count - WIDTH'(1);
              end else begin
                tc_pulse <= 1'b1;
                if (!mode) begin
                  count   <= shadow;
                  pending <= 1'b0;
                end else begin
                  state <= DONE;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (load_fire) begin
        shadow  <= load_data;
        pending <= 1'b1;
      end
    end
  end

`ifdef PDC_TC_COUNT_EN
  // Saturating count of terminal strobes; cleared by a start accepted from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_cnt <= '0;
    end else if (start && !stop && (state == IDLE)) begin
      tc_cnt <= '0;
    end else if (tc_pulse && (tc_cnt != {TC_CNT_W{1'b1}})) begin
      tc_cnt <= tc_cnt + TC_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_period_down_counter.sv
// Directed self-checking bench for period_down_counter (WIDTH=8).
module tb_period_down_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, en, start, stop, mode, load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready, zero, tc_pulse, busy;
  logic [WIDTH-1:0] count;
`ifdef PDC_TC_COUNT_EN
  logic [15:0]      tc_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  period_down_counter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .count      (count),
    .zero       (zero),
    .tc_pulse   (tc_pulse),
    .busy       (busy)
`ifdef PDC_TC_COUNT_EN
    ,
    .tc_cnt     (tc_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total_cnt++;
    if ({count, zero, tc_pulse, busy, load_ready} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset: count=%0d zero=%b tc=%b busy=%b ready=%b, want 0 1 0 0 1",
               count, zero, tc_pulse, busy, load_ready);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_cnt [8] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    logic       exp_tc  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    load_valid = 1'b1; load_data = 8'd3;
    step();
    load_valid = 1'b0;
    total_cnt++;
    if (load_ready !== 1'b0) $display("FAIL load_ready_after_load: got %b want 0", load_ready);
    else pass_cnt++;
    start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if ({count, busy, load_ready} !== {8'd3, 1'b1, 1'b1})
      $display("FAIL auto_start: count=%0d busy=%b ready=%b want 3 1 1", count, busy, load_ready);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      step();
      total_cnt++;
      if (count !== exp_cnt[i] || tc_pulse !== exp_tc[i] || zero !== (exp_cnt[i] == 8'd0))
        $display("FAIL auto_seq[%0d]: count=%0d tc=%b zero=%b want count=%0d tc=%b",
                 i, count, tc_pulse, zero, exp_cnt[i], exp_tc[i]);
      else pass_cnt++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total_cnt++;
    if ({count, busy, tc_pulse} !== {8'd3, 1'b0, 1'b0})
      $display("FAIL stop_hold: count=%0d busy=%b tc=%b want 3 0 0", count, busy, tc_pulse);
    else pass_cnt++;
  endtask

  task automatic test_one_shot();
    load_valid = 1'b1; load_data = 8'd2;
    step();
    load_valid = 1'b0;
    start = 1'b1; mode = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if ({count, busy} !== {8'd2, 1'b1}) $display("FAIL os_start: count=%0d busy=%b want 2 1", count, busy);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if ({count, tc_pulse, busy} !== {8'd0, 1'b0, 1'b1})
      $display("FAIL os_at_zero: count=%0d tc=%b busy=%b want 0 0 1", count, tc_pulse, busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({count, tc_pulse, busy} !== {8'd0, 1'b1, 1'b0})
      $display("FAIL os_terminal: count=%0d tc=%b busy=%b want 0 1 0", count, tc_pulse, busy);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if ({count, tc_pulse, busy} !== {8'd0, 1'b0, 1'b0})
      $display("FAIL os_done_hold: count=%0d tc=%b busy=%b want 0 0 0", count, tc_pulse, busy);
    else pass_cnt++;
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if ({count, busy} !== {8'd2, 1'b1}) $display("FAIL os_restart: count=%0d busy=%b want 2 1", count, busy);
    else pass_cnt++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_load_during_reload();
    load_valid = 1'b1; load_data = 8'd3;
    step();
    load_valid = 1'b0;
    start = 1'b1; mode = 1'b0; en = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    total_cnt++;
    if ({count, load_ready} !== {8'd0, 1'b1})
      $display("FAIL ldr_pre: count=%0d ready=%b want 0 1", count, load_ready);
    else pass_cnt++;
    load_valid = 1'b1; load_data = 8'd5;
    step();
    load_valid = 1'b0;
    total_cnt++;
    if ({count, load_ready, tc_pulse} !== {8'd3, 1'b0, 1'b1})
      $display("FAIL ldr_reload_old: count=%0d ready=%b tc=%b want 3 0 1", count, load_ready, tc_pulse);
    else pass_cnt++;
    step(); step(); step(); step();
    total_cnt++;
    if ({count, load_ready, tc_pulse} !== {8'd5, 1'b1, 1'b1})
      $display("FAIL ldr_reload_new: count=%0d ready=%b tc=%b want 5 1 1", count, load_ready, tc_pulse);
    else pass_cnt++;
  endtask

  task automatic test_en_toggle();
    logic       en_pat  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_cnt [8] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
    logic       exp_tc  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    stop = 1'b1;
    step();
    stop = 1'b0;
    load_valid = 1'b1; load_data = 8'd1;
    step();
    load_valid = 1'b0;
    start = 1'b1; en = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    total_cnt++;
    if (count !== 8'd1) $display("FAIL en_start: count=%0d want 1", count);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      en = en_pat[i];
      step();
      total_cnt++;
      if (count !== exp_cnt[i] || tc_pulse !== exp_tc[i] || busy !== 1'b1)
        $display("FAIL en_toggle[%0d]: count=%0d tc=%b busy=%b want count=%0d tc=%b busy=1",
                 i, count, tc_pulse, busy, exp_cnt[i], exp_tc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_n_zero();
    stop = 1'b1;
    step();
    stop = 1'b0;
    load_valid = 1'b1; load_data = 8'd0;
    step();
    load_valid = 1'b0;
    start = 1'b1; en = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({count, tc_pulse, busy} !== {8'd0, 1'b1, 1'b1})
        $display("FAIL n0_cont[%0d]: count=%0d tc=%b busy=%b want 0 1 1", i, count, tc_pulse, busy);
      else pass_cnt++;
    end
    en = 1'b0;
    step();
    total_cnt++;
    if ({count, tc_pulse, busy} !== {8'd0, 1'b0, 1'b1})
      $display("FAIL n0_en_low: count=%0d tc=%b busy=%b want 0 0 1", count, tc_pulse, busy);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid_run();
    en = 1'b1;
    load_valid = 1'b1; load_data = 8'd7;
    step();
    load_valid = 1'b0;
    total_cnt++;
    if ({count, load_ready, tc_pulse} !== {8'd0, 1'b0, 1'b1})
      $display("FAIL rst_pre: count=%0d ready=%b tc=%b want 0 0 1", count, load_ready, tc_pulse);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({count, tc_pulse, busy, load_ready, zero} !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b1})
      $display("FAIL rst_mid_run: count=%0d tc=%b busy=%b ready=%b zero=%b want 0 0 0 1 1",
               count, tc_pulse, busy, load_ready, zero);
    else pass_cnt++;
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if ({count, busy} !== {8'd0, 1'b1}) $display("FAIL rst_shadow_cleared: count=%0d busy=%b want 0 1", count, busy);
    else pass_cnt++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

`ifdef PDC_TC_COUNT_EN
  task automatic test_tc_cnt();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (tc_cnt !== 16'd0) $display("FAIL tc_cnt_reset: got %0d want 0", tc_cnt);
    else pass_cnt++;
    start = 1'b1; en = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 70000; i++) step();
    total_cnt++;
    if (tc_cnt !== 16'hFFFF) $display("FAIL tc_cnt_sat: got %h want ffff", tc_cnt);
    else pass_cnt++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if (tc_cnt !== 16'd0) $display("FAIL tc_cnt_clear: got %h want 0", tc_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    load_valid = 1'b0; load_data = '0;
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_load_during_reload();
    test_en_toggle();
    test_n_zero();
    test_rst_mid_run();
`ifdef PDC_TC_COUNT_EN
    test_tc_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
